// File: rtl/sc_game_pkg.sv
// Shared constants for the LED-matrix game field: state codes, LFSR taps,
// density levels and small pixel/LFSR helpers.
package sc_game_pkg;

  localparam int ROW_COUNT = 8;
  localparam int LFSR_W    = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b10;

  localparam logic [1:0] LVL_NONE   = 2'd0;
  localparam logic [1:0] LVL_SPARSE = 2'd1;
  localparam logic [1:0] LVL_ONE    = 2'd2;
  localparam logic [1:0] LVL_TWO    = 2'd3;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

  // Galois form: shift right, fold taps back in when a 1 falls out.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/sc_game_lfsr8.sv
// 8-bit Galois LFSR; load restores the seed, en advances one step.
module sc_game_lfsr8
  import sc_game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    value <= SEED;
    else if (load) value <= SEED;
    else if (en)   value <= lfsr_next(value);
  end

endmodule

// File: rtl/sc_game_field.sv
// Game-field engine: scrolling obstacle rows, bottom-row player, IDLE/PLAY/OVER
// control and blink-on-game-over, presented as eight row buses.
module sc_game_field
  import sc_game_pkg::*;
#(
  parameter int              DATAWIDTH_BUS = 8,
  parameter logic [7:0]      LFSR_SEED     = 8'hA5,
  parameter int              START_COL     = 3,
  parameter int              BLINK_TICKS   = 4
) (
  input  logic                     SC_GAMEFIELD_CLOCK_50,
  input  logic                     SC_GAMEFIELD_RESET_InLow,
  input  logic                     SC_GAMEFIELD_start_In,
  input  logic                     SC_GAMEFIELD_left_In,
  input  logic                     SC_GAMEFIELD_right_In,
  input  logic                     SC_GAMEFIELD_tick_InLow,
  input  logic [1:0]               SC_GAMEFIELD_level_InBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_GAMEFIELD_data0_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_GAMEFIELD_data1_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_GAMEFIELD_data2_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_GAMEFIELD_data3_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_GAMEFIELD_data4_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_GAMEFIELD_data5_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_GAMEFIELD_data6_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_GAMEFIELD_data7_OutBUS,
  output logic [1:0]               SC_GAMEFIELD_state_OutBUS,
  output logic [7:0]               SC_GAMEFIELD_score_OutBUS
);

  localparam logic [2:0] START_POS = 3'(START_COL);
  localparam logic [7:0] BLINK_MAX = 8'(BLINK_TICKS - 1);

  logic clk, rst_n;
  assign clk   = SC_GAMEFIELD_CLOCK_50;
  assign rst_n = SC_GAMEFIELD_RESET_InLow;

  logic [ROW_COUNT-1:0][DATAWIDTH_BUS-1:0] bg;
  logic [ROW_COUNT-1:0][DATAWIDTH_BUS-1:0] rows;
  logic [2:0]        pos;
  logic [1:0]        state;
  logic [7:0]        score, blink_cnt;
  logic              visible, odd;
  logic              prev_start, prev_left, prev_right, prev_tick;
  logic [LFSR_W-1:0] lfsr;
  logic [7:0]        new_row;

  logic start_ev, left_ev, right_ev, tick_ev, collide;
  assign start_ev = SC_GAMEFIELD_start_In & ~prev_start;
  assign left_ev  = SC_GAMEFIELD_left_In  & ~prev_left;
  assign right_ev = SC_GAMEFIELD_right_In & ~prev_right;
  // Falling edge of the active-low tick: a tick held low counts once.
  assign tick_ev  = ~SC_GAMEFIELD_tick_InLow & prev_tick;
  assign collide  = (state == ST_PLAY) && bg[0][pos];

  sc_game_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  ((state == ST_IDLE) && start_ev),
    .en    ((state == ST_PLAY) && !collide && tick_ev),
    .value (lfsr)
  );

  always_comb begin
    new_row = '0;
    case (SC_GAMEFIELD_level_InBUS)
      LVL_SPARSE: new_row = odd ? 8'h00 : onehot8(lfsr[2:0]);
      LVL_ONE:    new_row = onehot8(lfsr[2:0]);
      LVL_TWO:    new_row = onehot8(lfsr[2:0]) | onehot8(lfsr[5:3]);
      default:    new_row = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg         <= '0;
      pos        <= START_POS;
      state      <= ST_IDLE;
      score      <= '0;
      visible    <= 1'b1;
      blink_cnt  <= '0;
      odd        <= 1'b0;
      prev_start <= 1'b0;
      prev_left  <= 1'b0;
      prev_right <= 1'b0;
      prev_tick  <= 1'b1;
    end else begin
      prev_start <= SC_GAMEFIELD_start_In;
      prev_left  <= SC_GAMEFIELD_left_In;
      prev_right <= SC_GAMEFIELD_right_In;
      prev_tick  <= SC_GAMEFIELD_tick_InLow;
      case (state)
        ST_IDLE: begin
          bg  <= '0;
          pos <= START_POS;
          if (start_ev) begin
            state <= ST_PLAY;
            score <= '0;
            odd   <= 1'b0;
          end
        end
        ST_PLAY: begin
          // A hit freezes the frame as-is: no scroll, move or score that cycle.
          if (collide) begin
            state <= ST_OVER;
          end else begin
            if (tick_ev) begin
              bg    <= {new_row, bg[ROW_COUNT-1:1]};
              odd   <= ~odd;
              score <= (score == 8'hFF) ? score : score + 8'd1;
            end
            if (left_ev && !right_ev && pos != 3'd7)      pos <= pos + 3'd1;
            else if (right_ev && !left_ev && pos != 3'd0) pos <= pos - 3'd1;
          end
        end
        ST_OVER: begin
          if (start_ev) begin
            state     <= ST_IDLE;
            bg        <= '0;
            pos       <= START_POS;
            visible   <= 1'b1;
            blink_cnt <= '0;
          end else if (tick_ev) begin
            if (blink_cnt == BLINK_MAX) begin
              blink_cnt <= '0;
              visible   <= ~visible;
            end else begin
              blink_cnt <= blink_cnt + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rows[0] = visible ? (bg[0] | onehot8(pos)) : '0;
  for (genvar r = 1; r < ROW_COUNT; r++) begin : g_row
    assign rows[r] = visible ? bg[r] : '0;
  end

  assign SC_GAMEFIELD_data0_OutBUS = rows[0];
  assign SC_GAMEFIELD_data1_OutBUS = rows[1];
  assign SC_GAMEFIELD_data2_OutBUS = rows[2];
  assign SC_GAMEFIELD_data3_OutBUS = rows[3];
  assign SC_GAMEFIELD_data4_OutBUS = rows[4];
  assign SC_GAMEFIELD_data5_OutBUS = rows[5];
  assign SC_GAMEFIELD_data6_OutBUS = rows[6];
  assign SC_GAMEFIELD_data7_OutBUS = rows[7];
  assign SC_GAMEFIELD_state_OutBUS = state;
  assign SC_GAMEFIELD_score_OutBUS = score;

endmodule

// File: tb/tb_sc_game_field.sv
// Bench for sc_game_field: directed scenarios plus a long random run checked
// against a queue-based model of the game rules.
module tb_sc_game_field;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, left, right, tick_n;
  logic [1:0] level;
  logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7, sc;
  logic [1:0] st;

  sc_game_field dut (
    .SC_GAMEFIELD_CLOCK_50    (clk),
    .SC_GAMEFIELD_RESET_InLow (rst_n),
    .SC_GAMEFIELD_start_In    (start),
    .SC_GAMEFIELD_left_In     (left),
    .SC_GAMEFIELD_right_In    (right),
    .SC_GAMEFIELD_tick_InLow  (tick_n),
    .SC_GAMEFIELD_level_InBUS (level),
    .SC_GAMEFIELD_data0_OutBUS(d0),
    .SC_GAMEFIELD_data1_OutBUS(d1),
    .SC_GAMEFIELD_data2_OutBUS(d2),
    .SC_GAMEFIELD_data3_OutBUS(d3),
    .SC_GAMEFIELD_data4_OutBUS(d4),
    .SC_GAMEFIELD_data5_OutBUS(d5),
    .SC_GAMEFIELD_data6_OutBUS(d6),
    .SC_GAMEFIELD_data7_OutBUS(d7),
    .SC_GAMEFIELD_state_OutBUS(st),
    .SC_GAMEFIELD_score_OutBUS(sc)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: field is a queue, front = bottom row.
  logic [7:0] m_field[$];
  int         m_state, m_pos, m_score, m_blink;
  logic [7:0] m_lfsr;
  bit         m_odd, m_vis;
  bit         p_start, p_left, p_right, p_tick;

  function automatic logic [63:0] dut_rows();
    return {d7, d6, d5, d4, d3, d2, d1, d0};
  endfunction

  function automatic logic [63:0] mdl_rows();
    logic [63:0] v;
    logic [7:0]  row;
    v = '0;
    for (int r = 0; r < 8; r++) begin
      row = m_field[r];
      if (r == 0) row = row | 8'(1 << m_pos);
      if (!m_vis) row = 8'h00;
      v[r*8 +: 8] = row;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_field = {};
    repeat (8) m_field.push_back(8'h00);
    m_state = 0; m_pos = 3; m_score = 0; m_blink = 0;
    m_lfsr = 8'hA5; m_odd = 0; m_vis = 1;
    p_start = 0; p_left = 0; p_right = 0; p_tick = 1;
  endtask

  task automatic model_step(input bit s, input bit l, input bit r, input bit t_n,
                            input logic [1:0] lv);
    bit se, le, re, te;
    logic [7:0] row0, a, b, nr;
    se = s && !p_start; le = l && !p_left; re = r && !p_right; te = !t_n && p_tick;
    case (m_state)
      0: begin
        if (se) begin
          m_state = 1; m_lfsr = 8'hA5; m_score = 0; m_odd = 0;
        end
      end
      1: begin
        row0 = m_field[0];
        if (row0[m_pos]) begin
          m_state = 2;
        end else begin
          if (te) begin
            a  = 8'(1 << (m_lfsr % 8));
            b  = 8'(1 << ((m_lfsr / 8) % 8));
            nr = (lv == 0) ? 8'h00 : (lv == 1) ? (m_odd ? 8'h00 : a) :
                 (lv == 2) ? a : (a | b);
            void'(m_field.pop_front());
            m_field.push_back(nr);
            m_lfsr  = (m_lfsr / 2) ^ ((m_lfsr % 2 == 1) ? 8'hB8 : 8'h00);
            m_odd   = !m_odd;
            m_score = (m_score < 255) ? m_score + 1 : 255;
          end
          if (le && !re)      m_pos = (m_pos < 7) ? m_pos + 1 : 7;
          else if (re && !le) m_pos = (m_pos > 0) ? m_pos - 1 : 0;
        end
      end
      default: begin
        if (se) begin
          m_state = 0; m_pos = 3; m_vis = 1; m_blink = 0;
          foreach (m_field[i]) m_field[i] = 8'h00;
        end else if (te) begin
          m_blink++;
          if (m_blink == 4) begin m_blink = 0; m_vis = !m_vis; end
        end
      end
    endcase
    p_start = s; p_left = l; p_right = r; p_tick = t_n;
  endtask

  task automatic cycle(input bit s, input bit l, input bit r, input bit t_n);
    start = s; left = l; right = r; tick_n = t_n;
    @(posedge clk);
    model_step(s, l, r, t_n, level);
    #1;
  endtask

  task automatic press_start();  cycle(1, 0, 0, 1); cycle(0, 0, 0, 1); endtask
  task automatic press_left();   cycle(0, 1, 0, 1); cycle(0, 0, 0, 1); endtask
  task automatic press_right();  cycle(0, 0, 1, 1); cycle(0, 0, 0, 1); endtask
  task automatic pulse_tick();   cycle(0, 0, 0, 0); cycle(0, 0, 0, 1); endtask

  task automatic reset_dut();
    rst_n = 0; start = 0; left = 0; right = 0; tick_n = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    level = 2'd2;
    reset_dut();
    n_checks++;
    if (dut_rows() !== 64'h08 || st !== 2'b00 || sc !== 8'd0) begin
      n_errors++;
      $display("FAIL reset: rows=%h st=%b sc=%0d, want rows=%h st=00 sc=0", dut_rows(), st, sc, 64'h08);
    end
    pulse_tick(); press_left(); press_right();
    n_checks++;
    if (dut_rows() !== 64'h08 || st !== 2'b00 || sc !== 8'd0) begin
      n_errors++;
      $display("FAIL idle_ignore: rows=%h st=%b sc=%0d, want rows=%h st=00 sc=0", dut_rows(), st, sc, 64'h08);
    end
  endtask

  task automatic test_move();
    reset_dut(); level = 2'd0;
    press_start();
    n_checks++;
    if (st !== 2'b01) begin n_errors++; $display("FAIL start_play: st=%b want 01", st); end
    repeat (5) press_left();
    n_checks++;
    if (d0 !== 8'h80) begin n_errors++; $display("FAIL left_sat: d0=%h want 80", d0); end
    repeat (9) press_right();
    n_checks++;
    if (d0 !== 8'h01) begin n_errors++; $display("FAIL right_sat: d0=%h want 01", d0); end
    press_left();
    cycle(0, 1, 1, 1); cycle(0, 0, 0, 1);
    n_checks++;
    if (d0 !== 8'h02) begin n_errors++; $display("FAIL both_dirs: d0=%h want 02", d0); end
  endtask

  task automatic test_scroll();
    reset_dut(); level = 2'd2;
    press_start();
    pulse_tick();
    n_checks++;
    if (d7 !== 8'h20) begin n_errors++; $display("FAIL scroll1: d7=%h want 20", d7); end
    pulse_tick();
    n_checks++;
    if (d7 !== 8'h04 || d6 !== 8'h20 || sc !== 8'd2) begin
      n_errors++; $display("FAIL scroll2: d7=%h d6=%h sc=%0d want 04 20 2", d7, d6, sc);
    end
    reset_dut(); level = 2'd0;
    press_start();
    repeat (10) pulse_tick();
    n_checks++;
    if (dut_rows() !== 64'h08 || sc !== 8'd10) begin
      n_errors++; $display("FAIL level0_run: rows=%h sc=%0d want %h 10", dut_rows(), sc, 64'h08);
    end
  endtask

  task automatic test_collision();
    logic [63:0] snap;
    reset_dut(); level = 2'd2;
    press_start();
    press_left(); press_left();
    repeat (7) pulse_tick();
    cycle(0, 0, 0, 0);
    n_checks++;
    if (d0 !== 8'h20 || st !== 2'b01) begin
      n_errors++; $display("FAIL hit_row0: d0=%h st=%b want 20 01", d0, st);
    end
    cycle(0, 0, 0, 1);
    n_checks++;
    if (st !== 2'b10 || sc !== 8'd8) begin
      n_errors++; $display("FAIL game_over: st=%b sc=%0d want 10 8", st, sc);
    end
    snap = mdl_rows();
    n_checks++;
    if (dut_rows() !== snap) begin
      n_errors++; $display("FAIL over_field: rows=%h want %h", dut_rows(), snap);
    end
    repeat (3) pulse_tick();
    press_left();
    n_checks++;
    if (dut_rows() !== snap || sc !== 8'd8) begin
      n_errors++; $display("FAIL frozen: rows=%h sc=%0d want %h 8", dut_rows(), sc, snap);
    end
    pulse_tick();
    n_checks++;
    if (dut_rows() !== 64'h0) begin n_errors++; $display("FAIL blink_off: rows=%h want 0", dut_rows()); end
    repeat (4) pulse_tick();
    n_checks++;
    if (dut_rows() !== snap || st !== 2'b10) begin
      n_errors++; $display("FAIL blink_on: rows=%h st=%b want %h 10", dut_rows(), st, snap);
    end
    press_start();
    n_checks++;
    if (dut_rows() !== 64'h08 || st !== 2'b00 || sc !== 8'd8) begin
      n_errors++; $display("FAIL over_to_idle: rows=%h st=%b sc=%0d want %h 00 8", dut_rows(), st, sc, 64'h08);
    end
  endtask

  task automatic test_back_to_back();
    reset_dut(); level = 2'd2;
    press_start();
    cycle(0, 1, 0, 0);
    n_checks++;
    if (d7 !== 8'h20 || d0 !== 8'h10 || sc !== 8'd1) begin
      n_errors++; $display("FAIL tick_and_left: d7=%h d0=%h sc=%0d want 20 10 1", d7, d0, sc);
    end
    cycle(0, 0, 0, 1);
    repeat (20) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    n_checks++;
    if (sc !== 8'd2 || d7 !== 8'h04 || d6 !== 8'h20) begin
      n_errors++; $display("FAIL held_tick: sc=%0d d7=%h d6=%h want 2 04 20", sc, d7, d6);
    end
  endtask

  task automatic test_async_reset();
    reset_dut(); level = 2'd3;
    press_start();
    pulse_tick(); press_left(); pulse_tick();
    rst_n = 0;
    #2;
    n_checks++;
    if (dut_rows() !== 64'h08 || st !== 2'b00 || sc !== 8'd0) begin
      n_errors++; $display("FAIL async_reset: rows=%h st=%b sc=%0d want %h 00 0", dut_rows(), st, sc, 64'h08);
    end
    model_reset();
    #2 rst_n = 1;
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit s, l, r, t_n;
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) level = 2'($urandom_range(0, 3));
      s   = ($urandom_range(0, 19) == 0);
      l   = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 3) == 0);
      t_n = ($urandom_range(0, 2) != 0);
      cycle(s, l, r, t_n);
      n_checks++;
      if ({dut_rows(), st, sc} !== {mdl_rows(), 2'(m_state), 8'(m_score)}) begin
        n_errors++;
        $display("FAIL random[%0d]: rows=%h st=%b sc=%0d want rows=%h st=%0d sc=%0d",
                 i, dut_rows(), st, sc, mdl_rows(), m_state, m_score);
      end
    end
  endtask

  initial begin
    rst_n = 0; start = 0; left = 0; right = 0; tick_n = 1; level = 2'd0;
    model_reset();
    test_reset();
    test_move();
    test_scroll();
    test_collision();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sc_game_field.md
Name: sc_game_field

Overview:
- Game-field engine that produces the eight 8-bit row buses feeding the LED-matrix row/column transpose mux and the MAX7219 driver.
- Holds a scrolling obstacle field and a one-pixel player on the bottom row.
- Consumes debounced start/left/right buttons, the obstacle-density level from the level register, and the speed-comparator tick.
- Runs the IDLE/PLAY/OVER game state machine.

Parameters:
DATAWIDTH_BUS, 8, row width and number of rows (fixed at 8).
LFSR_SEED, 8'hA5, nonzero LFSR value loaded at reset and on every game start.
START_COL, 3, player column after reset and on entering IDLE.
BLINK_TICKS, 4, number of tick events between visibility toggles in OVER.

Ports:
SC_GAMEFIELD_CLOCK_50  in  1  system clock
SC_GAMEFIELD_RESET_InLow  in  1  asynchronous, active-low reset
SC_GAMEFIELD_start_In  in  1  debounced start button, active-high level
SC_GAMEFIELD_left_In  in  1  debounced left button, active-high level
SC_GAMEFIELD_right_In  in  1  debounced right button, active-high level
SC_GAMEFIELD_tick_InLow  in  1  speed-comparator output, active-low
SC_GAMEFIELD_level_InBUS  in  2  obstacle density level
SC_GAMEFIELD_data0_OutBUS..data7_OutBUS  out  8 each  row r, bit c = pixel; row 0 is the player row
SC_GAMEFIELD_state_OutBUS  out  2  00 IDLE, 01 PLAY, 10 OVER
SC_GAMEFIELD_score_OutBUS  out  8  scrolls survived, saturating

Behaviour:
- Reset is asynchronous and active-low: bg rows = 0, pos = START_COL, state = IDLE, lfsr = LFSR_SEED, score = 0, visible = 1, blink counter = 0, prev start/left/right = 0, prev tick = 1, odd flag = 0.
- Reset outputs: data0 = onehot(START_COL), data1..7 = 0, state = 00, score = 0.
- Edge events: start/left/right event = input 1 and prev 0. Tick event = tick_InLow 0 and prev 1, so a held-low tick counts once. Registers update at the end of the event cycle; outputs reflect the update the next cycle.
- Outputs are combinational from registers: data_r = visible ? (bg[r] | (r==0 ? onehot(pos) : 0)) : 0.
- IDLE:
  - bg held at 0; pos = START_COL.
  - start event -> PLAY, lfsr = LFSR_SEED, score = 0, odd flag = 0.
  - Moves and ticks ignored.
- PLAY, priority order each cycle:
  1. collision = bg[0][pos] on registered values. If set -> OVER; no scroll, move or score change that cycle.
  2. Otherwise, on tick: bg[i] <= bg[i+1] for i = 0..6; bg[7] <= newrow(lfsr, level); lfsr advances; odd flag toggles; score += 1, saturating at 255.
  3. Move: left event -> pos+1 (saturate at 7); right event -> pos-1 (saturate at 0); both in the same cycle -> no move. A move and a tick in the same cycle both apply.
  - start event ignored in PLAY.
- newrow, using the current lfsr before it advances:
  - level 0: 8'h00.
  - level 1: onehot(lfsr[2:0]) when odd flag = 0, else 8'h00.
  - level 2: onehot(lfsr[2:0]).
  - level 3: onehot(lfsr[2:0]) | onehot(lfsr[5:3]).
  - A row never has more than 2 bits set.
- LFSR: 8-bit Galois, shift right, XOR 8'hB8 when the shifted-out bit is 1. Example: A5 -> EA.
- OVER:
  - bg, pos and score frozen; buttons other than start ignored.
  - Each tick increments the blink counter; at BLINK_TICKS the counter resets and visible toggles.
  - start event -> IDLE: bg cleared, pos = START_COL, visible = 1, blink counter = 0; score held until the next start.
- State encoding 11 is unreachable; if entered, go to IDLE on the next clock.
- Reset mid-game returns every register to its reset value immediately, without a clock edge.

Decomposition:
- Package sc_game_pkg holds:
  - state encodings IDLE/PLAY/OVER;
  - LFSR width and tap constant 8'hB8;
  - level codes;
  - ROW_COUNT = 8.
- One sub-module, sc_game_lfsr8: 8-bit Galois LFSR with synchronous load and enable, async active-low reset to seed.
- Edge detectors, field shifter and FSM stay in the top module.

Test Plan:
1. Reset low then high -> data0 = 8'h08, data1..7 = 0, state = 00, score = 0. Tick and left pulses in IDLE -> no change.
2. Movement in PLAY, level 0: start; 5 left pulses -> data0 = 8'h80 (saturated); 9 right pulses -> data0 = 8'h01; left and right high in the same cycle -> unchanged.
3. Level 2, seed A5: tick 1 -> data7 = 8'h20. Tick 2 -> data7 = 8'h04, data6 = 8'h20, score = 2. Level 0 run of 10 ticks -> all rows empty, score = 10.
4. Collision, level 2: start, 2 left pulses (pos 5), 8 ticks -> 8'h20 reaches row 0 on tick 8; state = 10 one cycle later; score = 8. Further ticks do not scroll; after 4 ticks all outputs = 0; after 4 more the frozen field reappears.
5. Simultaneous events in PLAY: tick and left in the same cycle -> both applied. Tick held low 20 cycles -> exactly one scroll.
6. Reset pulled low mid-PLAY with no clock edge -> outputs equal reset values immediately. Start in OVER -> IDLE with cleared field.
